bus_arbit_rr4: RTL and testbench

//   Four-master round-robin arbiter for the shared system bus. Replaces the
//   two-master fixed arbiter when the bus grows to four requesters.

---
 rtl/bus_arbit_rr4_if.sv | 25 ++
 rtl/bus_arbit_rr4.sv | 128 ++++++++++++
 tb/tb_bus_arbit_rr4.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_arbit_rr4_if.sv
// Request/grant bundle between the four bus masters and the round-robin arbiter.
// The master modport drives requests; the slave modport is the arbiter side.
interface bus_arbit_rr4_if;
    logic [3:0] m_req;
    logic [3:0] m_grant;
    logic [1:0] grant_id;
    logic       grant_valid;
    logic       preempt;

    modport master (
        output m_req,
        input  m_grant,
        input  grant_id,
        input  grant_valid,
        input  preempt
    );

    modport slave (
        input  m_req,
        output m_grant,
        output grant_id,
        output grant_valid,
        output preempt
    );
endinterface

// File: rtl/bus_arbit_rr4.sv
// Four-master round-robin bus arbiter with registered one-hot grant, binary
// grant_id and a hold limit that forces rotation when others are waiting.
module bus_arbit_rr4 #(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 5
) (
    input  logic           clk,
    input  logic           reset_n,
    bus_arbit_rr4_if.slave bus
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic             HOLD_EN  = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] HOLD_LIM = HOLD_EN ? CNT_W'(MAX_HOLD - 1) : '0;
    localparam logic [CNT_W-1:0] HOLD_SAT = CNT_W'(MAX_HOLD);

    state_t           state_q, state_d;
    logic [3:0]       grant_q, grant_d;
    logic [1:0]       id_q, id_d;
    logic             valid_q, valid_d;
    logic             preempt_q, preempt_d;
    logic [1:0]       last_q, last_d;
    logic [CNT_W-1:0] hold_q, hold_d;

    logic [3:0] owner_mask;
    logic [3:0] others;
    logic [1:0] win;
    logic       expired;
    logic       take;

    // First requester found searching upward from base+1, wrapping mod 4.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] base);
        logic [1:0] idx;
        logic [1:0] sel;
        logic       found;
        sel   = base;
        found = 1'b0;
        for (int unsigned i = 1; i <= 4; i++) begin
            idx = base + 2'(i);
            if (!found && req[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            id_q      <= '0;
            valid_q   <= 1'b0;
            preempt_q <= 1'b0;
            last_q    <= 2'd3;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            id_q      <= id_d;
            valid_q   <= valid_d;
            preempt_q <= preempt_d;
            last_q    <= last_d;
            hold_q    <= hold_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        id_d      = id_q;
        valid_d   = valid_q;
        preempt_d = 1'b0;
        last_d    = last_q;
        hold_d    = hold_q;
        take      = 1'b0;

        // The owner is never a candidate, so release and expiry share one search.
        owner_mask = (state_q == GRANT) ? (4'b0001 << id_q) : 4'b0000;
        others     = bus.m_req & ~owner_mask;
        win        = rr_pick(others, last_q);
        expired    = HOLD_EN && (hold_q >= HOLD_LIM);

        case (state_q)
            IDLE: begin
                if (|bus.m_req) begin
                    take = 1'b1;
                end
            end
            GRANT: begin
                if (!bus.m_req[id_q]) begin
                    if (|others) begin
                        take = 1'b1;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                        valid_d = 1'b0;
                        hold_d  = '0;
                    end
                end else if (expired && (|others)) begin
                    take      = 1'b1;
                    preempt_d = 1'b1;
                end else if (HOLD_EN && (hold_q < HOLD_SAT)) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (take) begin
            state_d = GRANT;
            grant_d = 4'b0001 << win;
            id_d    = win;
            valid_d = 1'b1;
            last_d  = win;
            hold_d  = '0;
        end
    end

    assign bus.m_grant     = grant_q;
    assign bus.grant_id    = id_q;
    assign bus.grant_valid = valid_q;
    assign bus.preempt     = preempt_q;

endmodule

// File: tb/tb_bus_arbit_rr4.sv
// Self-checking bench for bus_arbit_rr4: vector table, corner sequences and a
// randomized run against a cycle-count reference model (limit 16 and unlimited).
module tb_bus_arbit_rr4;

    localparam int unsigned MAXH = 16;
    localparam int          WAIT_BOUND = 3 * MAXH + 3;

    logic clk = 1'b0;
    logic reset_n;

    bus_arbit_rr4_if bus ();
    bus_arbit_rr4_if bus0 ();

    bus_arbit_rr4 #(.MAX_HOLD(MAXH), .CNT_W(5)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    bus_arbit_rr4 #(.MAX_HOLD(0), .CNT_W(5)) u_dut_nolim (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus0)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0] req;
        logic [3:0] grant;
        logic [1:0] id;
        logic       valid;
        logic       pre;
    } vec_t;

    vec_t tbl [12];

    // Reference model state, index 0 = MAX_HOLD 16, index 1 = unlimited.
    int mo [2];
    int ml [2];
    int mh [2];
    int mid [2];
    bit mp [2];
    int mmax [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, want, $time);
        end
    endtask

    task automatic set_req(input logic [3:0] r);
        bus.m_req  = r;
        bus0.m_req = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        set_req(4'b0000);
        repeat (2) @(posedge clk);
        #1;
        check("rst_grant", 32'(bus.m_grant), 32'h0);
        check("rst_id", 32'(bus.grant_id), 32'h0);
        check("rst_valid", 32'(bus.grant_valid), 32'h0);
        check("rst_preempt", 32'(bus.preempt), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    function automatic int pick(input logic [3:0] req, input int base, input int excl);
        for (int j = 1; j <= 4; j++) begin
            int c;
            c = (base + j) % 4;
            if (c != excl && req[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mo[k]  = -1;
            ml[k]  = 3;
            mh[k]  = 0;
            mid[k] = 0;
            mp[k]  = 1'b0;
        end
        mmax[0] = MAXH;
        mmax[1] = 0;
    endtask

    // mh counts cycles the current owner has held the bus so far.
    task automatic model_step(input int k, input logic [3:0] req);
        int w;
        mp[k] = 1'b0;
        if (mo[k] < 0) begin
            w = pick(req, ml[k], -1);
            if (w >= 0) begin
                mo[k] = w; ml[k] = w; mid[k] = w; mh[k] = 1;
            end
        end else begin
            w = pick(req, ml[k], mo[k]);
            if (!req[mo[k]]) begin
                if (w >= 0) begin
                    mo[k] = w; ml[k] = w; mid[k] = w; mh[k] = 1;
                end else begin
                    mo[k] = -1; mh[k] = 0;
                end
            end else if (mmax[k] != 0 && mh[k] >= mmax[k] && w >= 0) begin
                mp[k] = 1'b1;
                mo[k] = w; ml[k] = w; mid[k] = w; mh[k] = 1;
            end else begin
                mh[k]++;
            end
        end
    endtask

    task automatic model_compare(input int k, input logic [3:0] g, input logic [1:0] id,
                                 input logic v, input logic p);
        logic [3:0] eg;
        eg = '0;
        if (mo[k] >= 0) eg[mo[k]] = 1'b1;
        check(k == 0 ? "rnd_grant" : "rnd0_grant", 32'(g), 32'(eg));
        check(k == 0 ? "rnd_id" : "rnd0_id", 32'(id), 32'(mid[k]));
        check(k == 0 ? "rnd_valid" : "rnd0_valid", 32'(v), 32'(mo[k] >= 0));
        check(k == 0 ? "rnd_preempt" : "rnd0_preempt", 32'(p), 32'(mp[k]));
        check(k == 0 ? "rnd_onehot" : "rnd0_onehot", 32'($onehot0(g)), 32'h1);
    endtask

    initial begin
        int wt [4];
        int wmax;
        logic [3:0] r;
        logic [3:0] eg;
        int owner;

        reset_n = 1'b0;
        set_req(4'b0000);

        tbl[0]  = '{4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0};
        tbl[1]  = '{4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0};
        tbl[2]  = '{4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0};
        tbl[3]  = '{4'b1110, 4'b0010, 2'd1, 1'b1, 1'b0};
        tbl[4]  = '{4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0};
        tbl[5]  = '{4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0};
        tbl[6]  = '{4'b1001, 4'b1000, 2'd3, 1'b1, 1'b0};
        tbl[7]  = '{4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0};
        tbl[8]  = '{4'b0101, 4'b0001, 2'd0, 1'b1, 1'b0};
        tbl[9]  = '{4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0};
        tbl[10] = '{4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0};
        tbl[11] = '{4'b1011, 4'b0010, 2'd1, 1'b1, 1'b0};

        do_reset();
        for (int i = 0; i < 12; i++) begin
            set_req(tbl[i].req);
            tick();
            check($sformatf("vec%0d_grant", i), 32'(bus.m_grant), 32'(tbl[i].grant));
            check($sformatf("vec%0d_id", i), 32'(bus.grant_id), 32'(tbl[i].id));
            check($sformatf("vec%0d_valid", i), 32'(bus.grant_valid), 32'(tbl[i].valid));
            check($sformatf("vec%0d_preempt", i), 32'(bus.preempt), 32'(tbl[i].pre));
        end

        // Full contention: 16-cycle slices in order 0,1,2,3,0; unlimited instance keeps master 0.
        do_reset();
        set_req(4'b1111);
        for (int c = 1; c <= 65; c++) begin
            tick();
            owner = ((c - 1) / 16) % 4;
            eg = '0;
            eg[owner] = 1'b1;
            check("rot_grant", 32'(bus.m_grant), 32'(eg));
            check("rot_preempt", 32'(bus.preempt), 32'(c > 1 && (c - 1) % 16 == 0));
            check("nolim_grant", 32'(bus0.m_grant), 32'h1);
            check("nolim_preempt", 32'(bus0.preempt), 32'h0);
        end

        // Lone requester past the limit, then a competitor arrives.
        do_reset();
        set_req(4'b0100);
        for (int c = 0; c < 40; c++) begin
            tick();
            check("solo_grant", 32'(bus.m_grant), 32'h4);
            check("solo_preempt", 32'(bus.preempt), 32'h0);
        end
        set_req(4'b0110);
        tick();
        check("late_grant", 32'(bus.m_grant), 32'h2);
        check("late_id", 32'(bus.grant_id), 32'h1);
        check("late_preempt", 32'(bus.preempt), 32'h1);
        tick();
        check("late_grant2", 32'(bus.m_grant), 32'h2);
        check("late_preempt2", 32'(bus.preempt), 32'h0);

        // Owner releases on the very edge its hold expires.
        do_reset();
        set_req(4'b1100);
        for (int c = 0; c < 16; c++) begin
            tick();
            check("exp_hold_grant", 32'(bus.m_grant), 32'h4);
            check("exp_hold_preempt", 32'(bus.preempt), 32'h0);
        end
        set_req(4'b1000);
        tick();
        check("exp_rel_grant", 32'(bus.m_grant), 32'h8);
        check("exp_rel_preempt", 32'(bus.preempt), 32'h0);

        // Asynchronous reset in the middle of a grant.
        do_reset();
        set_req(4'b0100);
        tick();
        check("mid_grant", 32'(bus.m_grant), 32'h4);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_grant", 32'(bus.m_grant), 32'h0);
        check("async_valid", 32'(bus.grant_valid), 32'h0);
        check("async_id", 32'(bus.grant_id), 32'h0);
        check("async_preempt", 32'(bus.preempt), 32'h0);
        #2;
        set_req(4'b0110);
        reset_n = 1'b1;
        tick();
        check("post_rst_grant", 32'(bus.m_grant), 32'h2);
        check("post_rst_id", 32'(bus.grant_id), 32'h1);

        // Randomized run against the reference model.
        do_reset();
        model_reset();
        for (int i = 0; i < 4; i++) wt[i] = 0;
        r = 4'b0000;
        for (int c = 0; c < 10000; c++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
            end
            set_req(r);
            tick();
            model_step(0, r);
            model_step(1, r);
            model_compare(0, bus.m_grant, bus.grant_id, bus.grant_valid, bus.preempt);
            model_compare(1, bus0.m_grant, bus0.grant_id, bus0.grant_valid, bus0.preempt);
            wmax = 0;
            for (int i = 0; i < 4; i++) begin
                if (r[i] && !bus.m_grant[i]) wt[i]++;
                else wt[i] = 0;
                if (wt[i] > wmax) wmax = wt[i];
            end
            check("starve", 32'(wmax > WAIT_BOUND), 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
